// File: rtl/conv_enc.sv
// Serial rate-1/2, K=3 convolutional encoder. Encodes one message bit per clock,
// appends two zero tail steps, then holds the assembled codeword until taken.
module conv_enc #(
  parameter  int         MSG_W = 4,
  parameter  logic [2:0] G0    = 3'b111,
  parameter  logic [2:0] G1    = 3'b101,
  localparam int         CW_W  = 2 * (MSG_W + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MSG_W-1:0] msg_in,
  input  logic             msg_valid,
  output logic             msg_ready,
  output logic [1:0]       sym_out,
  output logic             sym_valid,
  output logic [CW_W-1:0]  cw_out,
  output logic             cw_valid,
  input  logic             cw_ready
);

  localparam int K_W = $clog2(MSG_W + 3);
  localparam logic [K_W-1:0] K_DATA_END = K_W'(MSG_W - 1);
  localparam logic [K_W-1:0] K_TAIL_END = K_W'(MSG_W + 1);

  typedef enum logic [1:0] {IDLE, ENCODE, FLUSH, HOLD} state_t;

  state_t             state_q, state_d;
  logic [MSG_W-1:0]   msg_sr_q, msg_sr_d;
  logic [1:0]         st_q, st_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [1:0]         sym_q, sym_d;
  logic               sym_valid_q, sym_valid_d;
  logic [CW_W-1:0]    cw_q, cw_d;
  logic               cw_valid_q, cw_valid_d;

  logic               u;
  logic [2:0]         taps;
  logic [1:0]         sym_calc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      msg_sr_q    <= '0;
      st_q        <= '0;
      k_q         <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      cw_q        <= '0;
      cw_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      msg_sr_q    <= msg_sr_d;
      st_q        <= st_d;
      k_q         <= k_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      cw_q        <= cw_d;
      cw_valid_q  <= cw_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (msg_valid)              state_d = ENCODE;
      ENCODE:  if (k_q == K_DATA_END)      state_d = FLUSH;
      FLUSH:   if (k_q == K_TAIL_END)      state_d = HOLD;
      HOLD:    if (cw_valid_q && cw_ready) state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Tail steps feed zeros so every codeword terminates in state 00.
  always_comb begin
    u        = (state_q == ENCODE) ? msg_sr_q[MSG_W-1] : 1'b0;
    taps     = {u, st_q};
    sym_calc = {^(taps & G0), ^(taps & G1)};

    msg_sr_d    = msg_sr_q;
    st_d        = st_q;
    k_d         = k_q;
    sym_d       = sym_q;
    sym_valid_d = 1'b0;
    cw_d        = cw_q;
    cw_valid_d  = cw_valid_q;

    case (state_q)
      IDLE: begin
        if (msg_valid) begin
          msg_sr_d = msg_in;
          st_d     = '0;
          k_d      = '0;
          cw_d     = '0;
        end
      end
      ENCODE, FLUSH: begin
        sym_d       = sym_calc;
        sym_valid_d = 1'b1;
        cw_d        = cw_q | ({sym_calc, {(CW_W-2){1'b0}}} >> {k_q, 1'b0});
        st_d        = {u, st_q[1]};
        msg_sr_d    = msg_sr_q << 1;
        k_d         = k_q + 1'b1;
      end
      HOLD: begin
        if (!cw_valid_q)   cw_valid_d = 1'b1;
        else if (cw_ready) cw_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign msg_ready = (state_q == IDLE);
  assign sym_out   = sym_q;
  assign sym_valid = sym_valid_q;
  assign cw_out    = cw_q;
  assign cw_valid  = cw_valid_q;

endmodule

// File: tb/tb_conv_enc.sv
// Scoreboard bench for conv_enc: stimulus pushes hand-computed symbols/codewords,
// a negedge monitor pops and compares whenever the encoder presents output.
module tb_conv_enc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  msg_in = '0;
  logic        msg_valid = 1'b0;
  logic        msg_ready;
  logic [1:0]  sym_out;
  logic        sym_valid;
  logic [11:0] cw_out;
  logic        cw_valid;
  logic        cw_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [1:0]  sym_exp_q[$];
  logic [11:0] cw_exp_q[$];

  localparam logic [11:0] CW_TAB [16] = '{
    12'b000000000000, 12'b000000111011, 12'b000011101100, 12'b000011010111,
    12'b001110110000, 12'b001110001011, 12'b001101011100, 12'b001101100111,
    12'b111011000000, 12'b111011111011, 12'b111000101100, 12'b111000010111,
    12'b110101110000, 12'b110101001011, 12'b110110011100, 12'b110110100111
  };

  conv_enc dut (
    .clk       (clk),
    .rst       (rst),
    .msg_in    (msg_in),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .cw_out    (cw_out),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [11:0] cw, input int nsym, input bit with_cw);
    logic [11:0] c;
    c = cw;
    for (int i = 0; i < nsym; i++) sym_exp_q.push_back(c[11-2*i -: 2]);
    if (with_cw) cw_exp_q.push_back(cw);
  endtask

  // Caller is at a negedge; returns at the negedge after the acceptance edge.
  task automatic send(input logic [3:0] m, input logic [11:0] cw, input int nsym, input bit with_cw);
    int n;
    n = 0;
    while (!msg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'b0, msg_ready}, 32'd1);
    push_exp(cw, nsym, with_cw);
    msg_in    = m;
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
  endtask

  // Monitor: samples just after the negedge so same-edge input drives are visible.
  initial begin
    logic [1:0]  es;
    logic [11:0] ec;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (sym_valid) begin
          if (sym_exp_q.size() == 0) chk("sym_unexpected", {30'b0, sym_out}, 32'hDEAD);
          else begin
            es = sym_exp_q.pop_front();
            chk("sym_out", {30'b0, sym_out}, {30'b0, es});
          end
        end
        if (cw_valid && cw_ready) begin
          if (cw_exp_q.size() == 0) chk("cw_unexpected", {20'b0, cw_out}, 32'hDEAD);
          else begin
            ec = cw_exp_q.pop_front();
            chk("cw_out", {20'b0, cw_out}, {20'b0, ec});
          end
        end
      end
    end
  end

  initial begin
    logic [11:0] held;
    int n;

    // Reset values
    @(negedge clk);
    chk("rst_msg_ready", {31'b0, msg_ready}, 32'd1);
    chk("rst_sym_valid", {31'b0, sym_valid}, 32'd0);
    chk("rst_cw_valid",  {31'b0, cw_valid},  32'd0);
    chk("rst_sym_out",   {30'b0, sym_out},   32'd0);
    chk("rst_cw_out",    {20'b0, cw_out},    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1000 with cycle-accurate timing
    send(4'b1000, 12'b111011000000, 6, 1'b1);
    chk("t0_sym_valid", {31'b0, sym_valid}, 32'd0);
    chk("t0_msg_ready", {31'b0, msg_ready}, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("tN_sym_valid", {31'b0, sym_valid}, 32'd1);
      chk("tN_cw_valid",  {31'b0, cw_valid},  32'd0);
    end
    @(negedge clk);
    chk("t7_sym_valid", {31'b0, sym_valid}, 32'd0);
    chk("t7_cw_valid",  {31'b0, cw_valid},  32'd1);
    chk("t7_msg_ready", {31'b0, msg_ready}, 32'd0);
    @(negedge clk);
    chk("t8_msg_ready", {31'b0, msg_ready}, 32'd1);
    chk("t8_cw_valid",  {31'b0, cw_valid},  32'd0);

    send(4'b0001, 12'b000000111011, 6, 1'b1);
    send(4'b0011, 12'b000011010111, 6, 1'b1);

    // All 16 messages back-to-back
    for (int m = 0; m < 16; m++) send(4'(m), CW_TAB[m], 6, 1'b1);

    // Backpressure on 0101, with a pending message 1010 during HOLD
    n = 0;
    while (!msg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    cw_ready = 1'b0;
    send(4'b0101, 12'b001110001011, 6, 1'b1);
    n = 0;
    while (!cw_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_cw_valid_rise", {31'b0, cw_valid}, 32'd1);
    held      = 12'b001110001011;
    msg_in    = 4'b1010;
    msg_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_cw_valid",  {31'b0, cw_valid},  32'd1);
      chk("bp_cw_out",    {20'b0, cw_out},    {20'b0, held});
      chk("bp_msg_ready", {31'b0, msg_ready}, 32'd0);
      chk("bp_sym_valid", {31'b0, sym_valid}, 32'd0);
      @(negedge clk);
    end
    push_exp(12'b111000101100, 6, 1'b1);
    cw_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'b0, msg_ready}, 32'd1);
    chk("bp_release_cwv",   {31'b0, cw_valid},  32'd0);
    @(negedge clk);
    msg_valid = 1'b0;
    chk("bp_pending_taken", {31'b0, msg_ready}, 32'd0);

    // Reset while k=2 of 1111
    send(4'b1111, 12'b110110100111, 2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_msg_ready", {31'b0, msg_ready}, 32'd1);
    chk("mid_rst_sym_valid", {31'b0, sym_valid}, 32'd0);
    chk("mid_rst_cw_valid",  {31'b0, cw_valid},  32'd0);
    chk("mid_rst_sym_out",   {30'b0, sym_out},   32'd0);
    chk("mid_rst_cw_out",    {20'b0, cw_out},    32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(4'b1111, 12'b110110100111, 6, 1'b1);

    // 0000 with msg_valid toggling while busy
    send(4'b0000, 12'b000000000000, 6, 1'b1);
    msg_in = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      msg_valid = ~msg_valid;
      @(negedge clk);
    end
    msg_valid = 1'b0;

    // Drain
    n = 0;
    while ((sym_exp_q.size() != 0 || cw_exp_q.size() != 0 || !msg_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("sym_queue_empty", sym_exp_q.size(), 32'd0);
    chk("cw_queue_empty",  cw_exp_q.size(),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_enc.md
Name: conv_enc

Overview:
- Serial rate-1/2 convolutional encoder. Constraint length K=3, generators G0=7 (111) and G1=5 (101).
- Turns a 4-bit message into the 12-bit zero-terminated codeword that the matching hard-decision decoder consumes.
- Accepts one message per valid/ready handshake and encodes one bit per clock: 4 data steps, then 2 zero tail steps.
- Emits each 2-bit symbol as it is produced, then presents the full 12-bit codeword on a held valid/ready output.

Parameters:
- MSG_W, 4: message bits per codeword.
- G0, 3'b111: generator for the first symbol bit. Bit 2 taps the current input, bit 1 the previous input, bit 0 the input before that.
- G1, 3'b101: generator for the second symbol bit, same tap ordering as G0.
- CW_W, 2*(MSG_W+2): codeword width, 12 by default. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- msg_in  in  MSG_W  message; bit MSG_W-1 is encoded first.
- msg_valid  in  1  msg_in is valid.
- msg_ready  out  1  encoder can accept a message.
- sym_out  out  2  current symbol; [1] is the G0 output, [0] is the G1 output.
- sym_valid  out  1  sym_out is valid this cycle.
- cw_out  out  CW_W  assembled codeword.
- cw_valid  out  1  cw_out is complete and held.
- cw_ready  in  1  consumer takes cw_out.

Behaviour:
- Reset (async, rst=1):
  - State is IDLE.
  - msg_ready=1, sym_valid=0, cw_valid=0, sym_out=0, cw_out=0.
  - Shift register and step counter are cleared.
- State machine: IDLE -> ENCODE -> FLUSH -> HOLD -> IDLE.
- IDLE:
  - msg_ready=1.
  - On msg_valid & msg_ready, capture msg_in into msg_sr, clear the 2-bit state register {s1,s0} to 00, clear step counter k to 0, clear cw_out to 0, go to ENCODE.
- ENCODE (k=0..MSG_W-1, one clock per step):
  - Input bit u = msg_sr[MSG_W-1]; the tap vector is {u,s1,s0}.
  - sym_out[1] = XOR of the taps selected by G0; sym_out[0] = XOR of the taps selected by G1. Both are registered, so sym_valid=1 on the cycle after each step edge.
  - Symbol for step k is written into cw_out[CW_W-1-2k : CW_W-2-2k].
  - Update {s1,s0} <= {u,s1}; msg_sr shifts left by 1; k increments.
  - After step MSG_W-1, go to FLUSH.
- FLUSH (k=MSG_W..MSG_W+1):
  - Same update with u=0. Exactly 2 tail steps, returning the state register to 00.
  - After the last tail step, go to HOLD.
- HOLD:
  - cw_valid=1, sym_valid=0, cw_out stable.
  - On cw_ready=1, cw_valid drops on the next edge and the FSM returns to IDLE.
  - cw_out keeps its value until the next acceptance clears it.
- Timing:
  - Acceptance edge is T.
  - sym_valid=1 for exactly 6 consecutive cycles, after edges T+1..T+6.
  - cw_valid rises after edge T+7.
  - With cw_ready tied high, msg_ready returns after edge T+8, so minimum spacing is 8 cycles per message.
- msg_ready=0 in ENCODE, FLUSH and HOLD. msg_valid is ignored there, and msg_in may change freely.
- cw_ready outside HOLD is ignored.
- msg_valid and cw_ready may be high on the same HOLD cycle. Only the codeword transfer happens; the message is accepted in IDLE on a later cycle.
- Each codeword starts from state 00; there is no state carry-over between messages.
- Reset mid-operation aborts immediately. The partial codeword is discarded, and no cw_valid is produced for the aborted message.
- XOR reduction is 1-bit modulo-2; there is no other arithmetic.
- Linearity: cw(a^b) = cw(a)^cw(b).

Test Plan:
- msg_in=4'b1000, cw_ready=1:
  - sym_out sequence is 11,10,11,00,00,00.
  - cw_out = 12'b111011000000, cw_valid rising after T+7.
- msg_in=4'b0001 -> cw_out = 12'b000000111011. msg_in=4'b0011 -> 12'b000011010111.
- All 16 messages back-to-back, cw_ready=1. Expected codewords:
  - 0-3: 000000000000, 000000111011, 000011101100, 000011010111.
  - 4-7: 001110110000, 001110001011, 001101011100, 001101100111.
  - 8-11: 111011000000, 111011111011, 111000101100, 111000010111.
  - 12-15: 110101110000, 110101001011, 110110011100, 110110100111.
  - Each message 15 gives 110110100111.
- Backpressure: msg 4'b0101 with cw_ready=0 for 10 cycles.
  - cw_valid stays 1 and cw_out holds 001110001011 throughout.
  - msg_ready stays 0 and a pending msg_valid is not taken.
  - Releasing cw_ready completes the transfer, and msg_ready=1 follows.
- Reset at step k=2 of msg 4'b1111:
  - Outputs go immediately to their reset values, with no cw_valid.
  - The next msg 4'b1111 yields 110110100111.
- msg 4'b0000 with msg_valid toggling during ENCODE:
  - Only one acceptance occurs; cw_out = 0, and sym_out = 00 for all 6 steps.
